// File: rtl/mips_result_checker_pkg.sv
// mips_result_checker_pkg
//   Shared definitions for the MIPS result-bus checker.
//   - Default widths and depths, also used by the testbench.
//   - State encoding of the checker FSM.
//   - Small helpers that classify states for the status outputs.
package mips_result_checker_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_N_EXPECT = 16;
   localparam int DEF_TIMEOUT  = 4096;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_RUN  = 3'd2,
      ST_PASS = 3'd3,
      ST_FAIL = 3'd4
   } state_t;

   // ARM and RUN are the states in which a check is in progress.
   function automatic logic is_active(input state_t s);
      return (s == ST_ARM) || (s == ST_RUN);
   endfunction

   // PASS and FAIL are terminal until clear.
   function automatic logic is_final(input state_t s);
      return (s == ST_PASS) || (s == ST_FAIL);
   endfunction

endpackage

// File: rtl/mips_result_checker_exp_mem.sv
// mips_chk_exp_mem
//   Expected-value store for the result checker: N_EXPECT x DATA_W
//   registers, one synchronous write port and one asynchronous read port.
//   The contents are deliberately not reset, so a loaded list survives
//   reset and clear.
// Ports
//   clk    in   clock, rising edge
//   we     in   write strobe
//   waddr  in   write address; addresses >= N_EXPECT are dropped
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
module mips_chk_exp_mem #(
   parameter  int DATA_W   = 32,
   parameter  int N_EXPECT = 16,
   localparam int AW       = $clog2(N_EXPECT)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [0:N_EXPECT-1];

   // Write port; the range check matters only for non-power-of-two depths.
   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < 32'(N_EXPECT))) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/mips_result_checker.sv
// mips_result_checker
//   Watches the MIPS result bus, treats every change of the bus as an
//   event and compares events in order against a loaded expected list.
//   Reports pass, fail (mismatch) or fail by timeout.
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   out_bus    in   watched result bus
//   exp_we     in   expected-memory write strobe (IDLE only)
//   exp_addr   in   expected-memory write address
//   exp_data   in   expected value to write
//   exp_count  in   number of events to check, latched on start
//   start      in   begin a check (IDLE only)
//   clear      in   return to IDLE from any state; highest priority
//   busy       out  check in progress (ARM or RUN)
//   done       out  PASS or FAIL reached
//   pass       out  all events matched
//   fail       out  mismatch or timeout
//   timeout    out  the failure was a timeout
//   match_cnt  out  events matched so far
//   fail_idx   out  event index at failure
//   fail_got   out  bus value at mismatch, 0 on timeout
module mips_result_checker
   import mips_result_checker_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int N_EXPECT = DEF_N_EXPECT,
   parameter  int TIMEOUT  = DEF_TIMEOUT,
   localparam int AW       = $clog2(N_EXPECT),
   localparam int CW       = $clog2(N_EXPECT + 1),
   localparam int TW       = $clog2(TIMEOUT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] out_bus,
   input  logic              exp_we,
   input  logic [AW-1:0]     exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [CW-1:0]     exp_count,
   input  logic              start,
   input  logic              clear,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [CW-1:0]     match_cnt,
   output logic [CW-1:0]     fail_idx,
   output logic [DATA_W-1:0] fail_got
);

   state_t            state_r;
   state_t            next_s;
   logic [DATA_W-1:0] prev_r;
   logic [DATA_W-1:0] rd_data_s;
   logic [DATA_W-1:0] fail_got_r;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_clamp_s;
   logic [CW-1:0]     idx_r;
   logic [CW-1:0]     fail_idx_r;
   logic [TW-1:0]     timer_r;
   logic [AW-1:0]     rd_addr_s;
   logic              busy_r;
   logic              done_r;
   logic              pass_r;
   logic              fail_r;
   logic              timeout_r;
   logic              event_s;
   logic              hit_s;
   logic              expire_s;
   logic              last_s;
   logic              mem_we_s;
   logic              start_go_s;
   logic              match_go_s;
   logic              miss_go_s;
   logic              expire_go_s;
   logic              tick_s;

   // idx never reaches cnt while in RUN, so truncation to the memory index is safe.
   assign rd_addr_s   = AW'(idx_r);
   assign event_s     = (out_bus != prev_r);
   assign hit_s       = (out_bus == rd_data_s);
   assign expire_s    = (timer_r == TW'(TIMEOUT - 1));
   assign last_s      = ((idx_r + {{(CW-1){1'b0}}, 1'b1}) == cnt_r);
   assign cnt_clamp_s = (exp_count > CW'(N_EXPECT)) ? CW'(N_EXPECT) : exp_count;
   assign mem_we_s    = (state_r == ST_IDLE) && exp_we && !clear;

   mips_chk_exp_mem #(
      .DATA_W   (DATA_W),
      .N_EXPECT (N_EXPECT)
   ) u_exp_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (exp_addr),
      .wdata (exp_data),
      .raddr (rd_addr_s),
      .rdata (rd_data_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state decode and one-hot action strobes for the datapath.
   always_comb begin
      next_s      = state_r;
      start_go_s  = 1'b0;
      match_go_s  = 1'b0;
      miss_go_s   = 1'b0;
      expire_go_s = 1'b0;
      tick_s      = 1'b0;
      if (clear) begin
         next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  next_s     = ST_ARM;
                  start_go_s = 1'b1;
               end else begin
                  next_s = ST_IDLE;
               end
            end
            ST_ARM: begin
               if (cnt_r == {CW{1'b0}}) begin
                  next_s = ST_PASS;
               end else begin
                  next_s = ST_RUN;
               end
            end
            ST_RUN: begin
               // An event wins over a simultaneous timer expiry.
               if (event_s) begin
                  if (hit_s) begin
                     match_go_s = 1'b1;
                     if (last_s) begin
                        next_s = ST_PASS;
                     end else begin
                        next_s = ST_RUN;
                     end
                  end else begin
                     miss_go_s = 1'b1;
                     next_s    = ST_FAIL;
                  end
               end else if (expire_s) begin
                  expire_go_s = 1'b1;
                  next_s      = ST_FAIL;
               end else begin
                  tick_s = 1'b1;
                  next_s = ST_RUN;
               end
            end
            ST_PASS: next_s = ST_PASS;
            ST_FAIL: next_s = ST_FAIL;
            default: next_s = ST_IDLE;
         endcase
      end
   end

   // Counters, baseline register and failure capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_r     <= {DATA_W{1'b0}};
         cnt_r      <= {CW{1'b0}};
         idx_r      <= {CW{1'b0}};
         timer_r    <= {TW{1'b0}};
         timeout_r  <= 1'b0;
         fail_idx_r <= {CW{1'b0}};
         fail_got_r <= {DATA_W{1'b0}};
      end else if (clear) begin
         prev_r     <= {DATA_W{1'b0}};
         idx_r      <= {CW{1'b0}};
         timer_r    <= {TW{1'b0}};
         timeout_r  <= 1'b0;
         fail_idx_r <= {CW{1'b0}};
         fail_got_r <= {DATA_W{1'b0}};
      end else begin
         if (start_go_s) begin
            cnt_r      <= cnt_clamp_s;
            idx_r      <= {CW{1'b0}};
            timer_r    <= {TW{1'b0}};
            timeout_r  <= 1'b0;
            fail_idx_r <= {CW{1'b0}};
            fail_got_r <= {DATA_W{1'b0}};
         end else if (match_go_s) begin
            idx_r   <= idx_r + {{(CW-1){1'b0}}, 1'b1};
            timer_r <= {TW{1'b0}};
         end else if (miss_go_s) begin
            fail_idx_r <= idx_r;
            fail_got_r <= out_bus;
         end else if (expire_go_s) begin
            timeout_r  <= 1'b1;
            fail_idx_r <= idx_r;
            fail_got_r <= {DATA_W{1'b0}};
         end else if (tick_s) begin
            timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
         end
         // ARM captures the baseline; RUN keeps it one sample behind the bus.
         if (is_active(state_r)) begin
            prev_r <= out_bus;
         end
      end
   end

   // Status flags follow the state being entered, so they appear on the deciding edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
         fail_r <= 1'b0;
      end else begin
         busy_r <= is_active(next_s);
         done_r <= is_final(next_s);
         pass_r <= (next_s == ST_PASS);
         fail_r <= (next_s == ST_FAIL);
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign fail      = fail_r;
   assign timeout   = timeout_r;
   assign match_cnt = idx_r;
   assign fail_idx  = fail_idx_r;
   assign fail_got  = fail_got_r;

endmodule
